// File: rtl/arty_io_mem.sv
// arty_io_mem: board I/O and scratch memory reached through one valid/ready port.
//   Two-flop synchronisers on buttons and switches, per-button debounce with
//   rising-edge event latching, an LED register and a 2**MemAddrWidth-word RAM.
//   Ports:
//     clk_i, rst_ni              clock, async active-low reset
//     btn_i, sw_i                raw asynchronous buttons / switches
//     led_o, btn_evt_o           LED drive, OR of pending button events
//     req_valid_i/req_ready_o    request handshake (write, addr, wdata)
//     rsp_valid_o/rsp_ready_i    response handshake (rdata, err)
//   Address MSB=1 selects the RAM; MSB=0 selects registers
//   LED(0) BTN(1) SW(2) EVT(3). Other register addresses return an error.
//
//   state | meaning
//   IDLE  | ready for a request
//   RESP  | response presented, held until rsp_ready_i
module arty_io_mem #(
  parameter int unsigned LedWidth       = 4,
  parameter int unsigned BtnWidth       = 4,
  parameter int unsigned SwWidth        = 2,
  parameter int unsigned MemAddrWidth   = 3,
  parameter int unsigned DataWidth      = 8,
  parameter int unsigned DebounceCycles = 1000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [BtnWidth-1:0]     btn_i,
  input  logic [SwWidth-1:0]      sw_i,
  output logic [LedWidth-1:0]     led_o,
  output logic                    btn_evt_o,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [MemAddrWidth:0]   req_addr_i,
  input  logic [DataWidth-1:0]    req_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DataWidth-1:0]    rsp_rdata_o,
  output logic                    rsp_err_o
);

  localparam int unsigned Words = 2 ** MemAddrWidth;
  localparam int unsigned CntW  = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  typedef enum logic {IDLE, RESP} state_e;

  state_e                 state_q;
  logic [BtnWidth-1:0]    btn_s1_q, btn_s2_q;
  logic [SwWidth-1:0]     sw_s1_q, sw_s2_q;
  logic [BtnWidth-1:0]    stable_q, stable_d;
  logic [CntW-1:0]        cnt_q [BtnWidth];
  logic [CntW-1:0]        cnt_d [BtnWidth];
  logic [BtnWidth-1:0]    evt_q, evt_d, evt_clr;
  logic                   btn_evt_q;
  logic [LedWidth-1:0]    led_q;
  logic [DataWidth-1:0]   mem_q [Words];
  logic                   req_ready_q, rsp_valid_q, rsp_err_q;
  logic [DataWidth-1:0]   rsp_rdata_q;

  logic                    accept, is_ram, reg_hit;
  logic [MemAddrWidth-1:0] idx;
  logic [1:0]              reg_sel;
  logic [DataWidth-1:0]    rd_data;

  assign accept  = req_valid_i & (state_q == IDLE);
  assign is_ram  = req_addr_i[MemAddrWidth];
  assign idx     = req_addr_i[MemAddrWidth-1:0];
  // Shift rather than a slice so MemAddrWidth=2 still elaborates.
  assign reg_hit = (idx >> 2) == '0;
  assign reg_sel = idx[1:0];

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < BtnWidth; i++) begin
      cnt_d[i] = '0;
      if (btn_s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) stable_d[i] = btn_s2_q[i];
        else                    cnt_d[i]    = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_comb begin
    evt_clr = '0;
    if (accept && req_write_i && !is_ram && reg_hit && reg_sel == 2'd3)
      evt_clr = req_wdata_i[BtnWidth-1:0];
    // A rising edge in the same cycle as a clear keeps the event pending.
    evt_d = (evt_q & ~evt_clr) | (stable_d & ~stable_q);
  end

  // Reads see pre-update state of every register written in the same cycle.
  always_comb begin
    rd_data = '0;
    if (is_ram) rd_data = mem_q[idx];
    else if (reg_hit) begin
      case (reg_sel)
        2'd0:    rd_data = DataWidth'(led_q);
        2'd1:    rd_data = DataWidth'(stable_q);
        2'd2:    rd_data = DataWidth'(sw_s2_q);
        default: rd_data = DataWidth'(evt_q);
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      stable_q  <= '0;
      evt_q     <= '0;
      btn_evt_q <= 1'b0;
      led_q     <= '0;
      for (int i = 0; i < BtnWidth; i++) cnt_q[i] <= '0;
      for (int w = 0; w < Words; w++) mem_q[w] <= '0;
    end else begin
      btn_s1_q  <= btn_i;
      btn_s2_q  <= btn_s1_q;
      sw_s1_q   <= sw_i;
      sw_s2_q   <= sw_s1_q;
      stable_q  <= stable_d;
      evt_q     <= evt_d;
      btn_evt_q <= |evt_d;
      for (int i = 0; i < BtnWidth; i++) cnt_q[i] <= cnt_d[i];
      if (accept && req_write_i) begin
        if (is_ram) mem_q[idx] <= req_wdata_i;
        else if (reg_hit && reg_sel == 2'd0) led_q <= req_wdata_i[LedWidth-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            state_q     <= RESP;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !is_ram && !reg_hit;
            rsp_rdata_q <= (req_write_i || (!is_ram && !reg_hit)) ? '0 : rd_data;
          end
        end
        default: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign led_o       = led_q;
  assign btn_evt_o   = btn_evt_q;
  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
